fifo_serial_tx: RTL

- Downstream consumer on the read side of the synchronous FIFO.
- Pops one DATA_WIDTH word whenever the FIFO is non-empty and the block is enabled.
- Shifts each word out on a single-wire asynchronous serial line: one start bit (0), DATA_WIDTH data bits LSB-first, one stop bit (1).
- Drives the FIFO cons-side handshake (`rd_en`, sampling `rd_data` and `empty`). It is the link between the core's output FIFO and the external pin.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/serial_baud_cnt.sv | 31 +++
 rtl/fifo_serial_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_pkg;

  // Word width carried through the core's output FIFO.
  localparam int DATA_WIDTH = 8;

  // Transmitter frame sequencer states.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_POP,
    TX_LOAD,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Level of the serial line when no frame is being sent (also the stop bit level).
  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_baud_cnt.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter with a wrap tick.
// Latency: tick is high on the cycle the count equals CLKS_PER_BIT-1; clr restarts at 0 next cycle.
// Backpressure: none; clr takes priority over counting.
module serial_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Count one bit period, restarting on clear or at the end of the period.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the output FIFO and sends each as an async serial frame (start, LSB-first data, stop).
// Latency: start bit begins 3 cycles after IDLE sees en && !fifo_empty; frame is (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
// Backpressure: pops only from IDLE when en is high and the FIFO is non-empty; one word in flight at a time.
module fifo_serial_tx
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  baud_tick;
  logic                  baud_clr;

  // The bit timer restarts on every state change so each bit gets a full period.
  assign baud_clr = (state_d != state_q) || (state_q == TX_LOAD);

  serial_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(baud_tick)
  );

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing through pop, load, start, data and stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (en && !fifo_empty) state_d = TX_POP;
      TX_POP:   state_d = TX_LOAD;
      TX_LOAD:  state_d = TX_START;
      TX_START: if (baud_tick) state_d = TX_DATA;
      TX_DATA:  if (baud_tick && (bit_cnt_q == LAST_BIT)) state_d = TX_STOP;
      TX_STOP:  if (baud_tick) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  // Shift register and bit counter: load the popped word, shift one bit per period.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (state_q == TX_LOAD) begin
      shift_q   <= fifo_rd_data;
      bit_cnt_q <= '0;
    end else if ((state_q == TX_DATA) && baud_tick) begin
      shift_q   <= shift_q >> 1;
      bit_cnt_q <= bit_cnt_q + BW'(1);
    end
  end

  // Moore output decode from the registered state and timer.
  always_comb begin
    tx         = TX_IDLE_LEVEL;
    busy       = (state_q != TX_IDLE);
    fifo_rd_en = (state_q == TX_POP);
    frame_done = 1'b0;
    case (state_q)
      TX_START: tx = ~TX_IDLE_LEVEL;
      TX_DATA:  tx = shift_q[0];
      TX_STOP:  frame_done = baud_tick;
      default:  tx = TX_IDLE_LEVEL;
    endcase
  end

  a_pop_from_idle: assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en |-> (!$past(fifo_empty) && ($past(state_q) == TX_IDLE)));

  a_single_pop: assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en |=> !fifo_rd_en);

  a_idle_line: assert property (@(posedge clk) disable iff (rst)
    (state_q == TX_IDLE) |-> (tx && !busy));

  a_done_to_idle: assert property (@(posedge clk) disable iff (rst)
    frame_done |=> (state_q == TX_IDLE));

endmodule
